// File: rtl/bus_copy_initiator.sv
// Bus initiator copying a block of 32-bit words src->dst, one outstanding read at a time.
// Request outputs are registered and held stable until acked; one idle cycle follows each write ack.
module bus_copy_initiator #(
  parameter int ADR_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADR_WIDTH-1:0] src_addr_bi,
  input  logic [ADR_WIDTH-1:0] dst_addr_bi,
  input  logic [LEN_WIDTH-1:0] len_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [ADR_WIDTH-1:0] bus_addr_bo,
  output logic [3:0]           bus_be_bo,
  output logic [31:0]          bus_wdata_bo,
  input  logic                 bus_ack_i,
  input  logic                 bus_resp_i,
  input  logic [31:0]          bus_rdata_bi
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [ADR_WIDTH-1:0] WORD = ADR_WIDTH'(4);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  state_t               state_q, state_d;
  logic [ADR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [31:0]          data_q, data_d;
  logic                 eflag_q, eflag_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [ADR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    eflag_d = eflag_q;
    case (state_q)
      IDLE: if (start_i) begin
        src_d   = src_addr_bi & ~ADR_WIDTH'(3);
        dst_d   = dst_addr_bi & ~ADR_WIDTH'(3);
        rem_d   = len_bi;
        tmo_d   = '0;
        eflag_d = 1'b0;
        state_d = (len_bi != '0) ? RD_REQ : FIN;
      end
      RD_REQ: if (req_q && bus_ack_i) begin
        tmo_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus_resp_i) begin
          data_d  = bus_rdata_bi;
          state_d = WR_REQ;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          eflag_d = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WR_REQ: if (req_q && bus_ack_i) begin
        src_d   = src_q + WORD;
        dst_d   = dst_q + WORD;
        rem_d   = rem_q - LEN_WIDTH'(1);
        state_d = (rem_q == LEN_WIDTH'(1)) ? FIN : RD_REQ;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entering RD_REQ straight from a write ack spends one cycle with req low.
    req_d   = (state_d == WR_REQ) || ((state_d == RD_REQ) && (state_q != WR_REQ));
    we_d    = (state_d == WR_REQ);
    addr_d  = !req_d ? '0 : (we_d ? dst_d : src_d);
    be_d    = req_d ? 4'hF : 4'h0;
    wdata_d = we_d ? data_d : wdata_q;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
    err_d   = done_d && eflag_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      eflag_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      eflag_q <= eflag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign bus_req_o    = req_q;
  assign bus_we_o     = we_q;
  assign bus_addr_bo  = addr_q;
  assign bus_be_bo    = be_q;
  assign bus_wdata_bo = wdata_q;

endmodule
